ifu_fetch: RTL and testbench

//  Instruction fetch unit; upstream end of the fetch->decode valid/ready link. Owns the

---
 rtl/ifu_fetch_if.sv | 34 +++
 rtl/ifu_fetch.sv | 84 ++++++++
 tb/tb_ifu_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus bundle: AXI4-Lite read channel toward memory
// plus the valid/ready link and PC feedback toward decode.
interface ifu_fetch_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        ifu_send_valid;
   logic        ifu_recv_ready;
   logic [31:0] pc_next;
   logic        pc_write_enable;
   logic        fetch_error;

   modport master (
      output araddr, arvalid, rready,
      output instruction, pc, ifu_send_valid,
      output fetch_error,
      input  arready, rdata, rresp, rvalid,
      input  ifu_recv_ready, pc_next, pc_write_enable
   );

   modport slave (
      input  araddr, arvalid, rready,
      input  instruction, pc, ifu_send_valid,
      input  fetch_error,
      output arready, rdata, rresp, rvalid,
      output ifu_recv_ready, pc_next, pc_write_enable
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one instruction in flight, AXI4-Lite read,
// hands {instruction, pc} to decode and waits for the resolved next PC.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   typedef enum logic [2:0] {
      REQ, RESP, SEND, WAIT_PC, ERR
   } state_t;

   state_t state, state_n;
   logic   ar_hs, r_hs, d_hs;
   logic   rsp_ok, pc_ok, pc_take;

   assign ar_hs   = bus.arvalid & bus.arready;
   assign r_hs    = bus.rready & bus.rvalid;
   assign d_hs    = bus.ifu_send_valid & bus.ifu_recv_ready;
   assign rsp_ok  = (bus.rresp == 2'b00);
   assign pc_ok   = (bus.pc_next[1:0] == 2'b00);
   // A PC update is honoured in WAIT_PC or together with the decode handshake
   assign pc_take = bus.pc_write_enable &
                    ((state == WAIT_PC) | ((state == SEND) & d_hs));
   assign bus.araddr = bus.pc;

   always_ff @(posedge clk) begin
      if (rst) state <= REQ;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         REQ:     if (ar_hs) state_n = RESP;
         RESP:    if (r_hs) state_n = rsp_ok ? SEND : ERR;
         SEND: begin
            if (d_hs) begin
               if (pc_take) state_n = pc_ok ? REQ : ERR;
               else         state_n = WAIT_PC;
            end
         end
         WAIT_PC: if (pc_take) state_n = pc_ok ? REQ : ERR;
         ERR:     state_n = ERR;
         default: state_n = ERR;
      endcase
   end

   always_comb begin
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      unique case (1'b1)
         (state == REQ):  bus.arvalid = 1'b1;
         (state == RESP): bus.rready  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pc             <= RESET_PC;
         bus.instruction    <= '0;
         bus.ifu_send_valid <= 1'b0;
         bus.fetch_error    <= 1'b0;
      end else begin
         if (r_hs) begin
            if (rsp_ok) begin
               bus.instruction    <= bus.rdata;
               bus.ifu_send_valid <= 1'b1;
            end else begin
               bus.fetch_error    <= 1'b1;
            end
         end
         if (d_hs) bus.ifu_send_valid <= 1'b0;
         if (pc_take) begin
            if (pc_ok) bus.pc          <= bus.pc_next;
            else       bus.fetch_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: scripted memory and decode,
// fetched words checked against a scoreboard of driven R beats.
module tb_ifu_fetch;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err = 0;
   logic [63:0] sb[$];

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic ar_phase(input int stall, input logic [31:0] addr);
      bus.arready = 1'b0;
      chk1("arvalid", bus.arvalid, 1'b1);
      chk("araddr", bus.araddr, addr);
      chk1("no_rready_req", bus.rready, 1'b0);
      for (int i = 0; i < stall; i++) begin
         step();
         chk1("arvalid_hold", bus.arvalid, 1'b1);
         chk("araddr_hold", bus.araddr, addr);
         chk1("no_rready_stall", bus.rready, 1'b0);
      end
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      chk1("rready", bus.rready, 1'b1);
      chk1("arvalid_drop", bus.arvalid, 1'b0);
   endtask

   task automatic r_phase(input logic [31:0] data, input logic [1:0] resp,
                          input logic [31:0] addr);
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rresp  = resp;
      if (resp == 2'b00) sb.push_back({data, addr});
      step();
      bus.rvalid = 1'b0;
      bus.rdata  = '0;
      bus.rresp  = 2'b00;
   endtask

   task automatic dec_phase(input int stall, input bit same,
                            input logic [31:0] pcn);
      logic [63:0] e;
      int t;
      t = 0;
      while (bus.ifu_send_valid !== 1'b1 && t < 20) begin
         step();
         t++;
      end
      chk1("send_valid", bus.ifu_send_valid, 1'b1);
      n_checks++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL sb_empty: observed 0 entries expected 1");
      end
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      for (int i = 0; i < stall; i++) begin
         chk("instr_stall", bus.instruction, e[63:32]);
         chk("pc_stall", bus.pc, e[31:0]);
         chk1("valid_stall", bus.ifu_send_valid, 1'b1);
         step();
      end
      chk("instruction", bus.instruction, e[63:32]);
      chk("pc", bus.pc, e[31:0]);
      bus.ifu_recv_ready = 1'b1;
      if (same) begin
         bus.pc_write_enable = 1'b1;
         bus.pc_next         = pcn;
      end
      step();
      bus.ifu_recv_ready  = 1'b0;
      bus.pc_write_enable = 1'b0;
      chk1("send_drop", bus.ifu_send_valid, 1'b0);
   endtask

   task automatic pc_update(input logic [31:0] pcn);
      chk1("wait_no_ar", bus.arvalid, 1'b0);
      bus.pc_write_enable = 1'b1;
      bus.pc_next         = pcn;
      step();
      bus.pc_write_enable = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_pc", bus.pc, RPC);
      chk("rst_instr", bus.instruction, 32'h0);
      chk1("rst_send_valid", bus.ifu_send_valid, 1'b0);
      chk1("rst_rready", bus.rready, 1'b0);
      chk1("rst_fetch_error", bus.fetch_error, 1'b0);
   endtask

   initial begin
      bus.arready         = 1'b0;
      bus.rdata           = '0;
      bus.rresp           = 2'b00;
      bus.rvalid          = 1'b0;
      bus.ifu_recv_ready  = 1'b0;
      bus.pc_next         = '0;
      bus.pc_write_enable = 1'b0;

      rst = 1'b1;
      step();
      step();
      reset_checks();
      rst = 1'b0;

      // basic fetch, then PC update through WAIT_PC
      ar_phase(0, RPC);
      r_phase(32'h0000_0413, 2'b00, RPC);
      dec_phase(0, 1'b0, '0);
      step();
      chk1("wait_hold_ar", bus.arvalid, 1'b0);
      pc_update(32'h8000_0010);

      // AR stall, decode stall, same-cycle PC update
      ar_phase(3, 32'h8000_0010);
      r_phase(32'h0010_0093, 2'b00, 32'h8000_0010);
      dec_phase(5, 1'b1, 32'h8000_0020);
      chk1("same_cycle_ar", bus.arvalid, 1'b1);
      chk("same_cycle_addr", bus.araddr, 32'h8000_0020);

      // pc_write_enable in REQ is ignored
      bus.pc_write_enable = 1'b1;
      bus.pc_next         = 32'h8000_0040;
      step();
      bus.pc_write_enable = 1'b0;
      chk("ignore_pwe_addr", bus.araddr, 32'h8000_0020);

      // misaligned next PC -> ERR
      ar_phase(0, 32'h8000_0020);
      r_phase(32'h0020_0113, 2'b00, 32'h8000_0020);
      dec_phase(0, 1'b0, '0);
      pc_update(32'h8000_0012);
      chk1("misalign_err", bus.fetch_error, 1'b1);
      chk("misalign_pc", bus.pc, 32'h8000_0020);
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("err_no_ar", bus.arvalid, 1'b0);
         chk1("err_no_send", bus.ifu_send_valid, 1'b0);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      reset_checks();

      // error response -> ERR
      ar_phase(0, RPC);
      r_phase(32'hdead_beef, 2'b10, RPC);
      chk1("rresp_err", bus.fetch_error, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk1("rerr_no_ar", bus.arvalid, 1'b0);
         chk1("rerr_no_rready", bus.rready, 1'b0);
         chk1("rerr_no_send", bus.ifu_send_valid, 1'b0);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      reset_checks();

      // reset while a response is outstanding
      ar_phase(0, RPC);
      r_phase(32'h0030_0193, 2'b00, RPC);
      dec_phase(0, 1'b1, 32'h8000_0008);
      ar_phase(0, 32'h8000_0008);
      rst = 1'b1;
      step();
      rst = 1'b0;
      reset_checks();
      chk1("rst_resp_ar", bus.arvalid, 1'b1);
      ar_phase(0, RPC);
      r_phase(32'h0040_0213, 2'b00, RPC);
      dec_phase(0, 1'b0, '0);

      n_checks++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
